// File: rtl/pe_rdport_arbiter.sv
// pe_rdport_arbiter: round-robin sharing of one synchronous memory read port among NUM_PE PE controllers
module pe_rdport_arbiter #(
    parameter int NUM_PE = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_words,
    input  logic [NUM_PE-1:0]        req,
    input  logic [NUM_PE*ADDR_W-1:0] req_addr,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [NUM_PE-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [NUM_PE-1:0]        read_done,
    output logic                     done,
    output logic                     busy,
    output logic                     err
);
    localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, stateNext;
    logic [NUM_PE-1:0] pending, accept, grant;
    logic [ADDR_W-1:0] addrLat [NUM_PE];
    logic [CNT_W-1:0]  words;
    logic [CNT_W-1:0]  issCnt [NUM_PE];
    logic [CNT_W-1:0]  rcvCnt [NUM_PE];
    logic [NUM_PE-1:0] tagPipe [RD_LAT+1];
    logic [PW-1:0]     rrPtr, gntIdx;
    logic              found, allIssued, pipeEmpty, startOk, errEvent;
    int                idx;

    always_comb begin
        grant  = '0;
        gntIdx = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_PE; k++) begin
            idx = (int'(rrPtr) + k) % NUM_PE;
            if (!found && pending[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gntIdx      = PW'(idx);
            end
        end
    end

    always_comb begin
        allIssued = 1'b1;
        pipeEmpty = 1'b1;
        accept    = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            allIssued = allIssued && (issCnt[i] == words);
            accept[i] = req[i] && state == RUN && !pending[i] && issCnt[i] != words;
        end
        for (int k = 0; k <= RD_LAT; k++)
            pipeEmpty = pipeEmpty && (tagPipe[k] == '0);
    end

    assign startOk  = start && state == IDLE;
    assign errEvent = (start && state != IDLE) || |(req & ~accept);
    assign busy     = state != IDLE;

    always_comb begin
        stateNext = startOk                        ? RUN   :
                    (state == RUN && allIssued)    ? DRAIN :
                    (state == DRAIN && pipeEmpty)  ? IDLE  : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // tagPipe[0] lines up with mem_en, tagPipe[RD_LAT] with mem_rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            rrPtr     <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            read_done <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            words     <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                addrLat[i] <= '0;
                issCnt[i]  <= '0;
                rcvCnt[i]  <= '0;
            end
            for (int k = 0; k <= RD_LAT; k++)
                tagPipe[k] <= '0;
        end else begin
            pending <= (pending & ~grant) | accept;
            mem_en  <= found;
            if (found) begin
                mem_addr <= addrLat[gntIdx];
                rrPtr    <= (gntIdx == PW'(NUM_PE-1)) ? '0 : gntIdx + PW'(1);
            end
            tagPipe[0] <= grant;
            for (int k = 1; k <= RD_LAT; k++)
                tagPipe[k] <= tagPipe[k-1];
            rsp_valid <= tagPipe[RD_LAT];
            if (|tagPipe[RD_LAT])
                rsp_data <= mem_rdata;
            done <= state == DRAIN && pipeEmpty;
            err  <= startOk ? 1'b0 : err | errEvent;
            for (int i = 0; i < NUM_PE; i++) begin
                if (accept[i])
                    addrLat[i] <= req_addr[i*ADDR_W +: ADDR_W];
                if (grant[i] && issCnt[i] != words)
                    issCnt[i] <= issCnt[i] + CNT_W'(1);
                if (tagPipe[RD_LAT][i]) begin
                    rcvCnt[i] <= rcvCnt[i] + CNT_W'(1);
                    if (rcvCnt[i] + CNT_W'(1) == words)
                        read_done[i] <= 1'b1;
                end
            end
            if (startOk) begin
                words     <= cfg_words;
                read_done <= {NUM_PE{cfg_words == '0}};
                for (int i = 0; i < NUM_PE; i++) begin
                    issCnt[i] <= '0;
                    rcvCnt[i] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_rdport_arbiter.sv
// tb_pe_rdport_arbiter: directed and randomized checks of pe_rdport_arbiter against a transaction-level model
module tb_pe_rdport_arbiter;
    localparam int NP = 4, AW = 10, DW = 64, RL = 2, CW = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [CW-1:0]     cfg_words = '0;
    logic [NP-1:0]     req = '0;
    logic [NP*AW-1:0]  req_addr = '0;
    logic              mem_en, done, busy, err;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rdata, rsp_data;
    logic [NP-1:0]     rsp_valid, read_done;

    pe_rdport_arbiter #(.NUM_PE(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_words(cfg_words), .req(req),
        .req_addr(req_addr), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .read_done(read_done), .done(done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        return {6'h15, a, 6'h2A, ~a, 32'(a) * 32'h9E3779B1};
    endfunction

    logic [DW-1:0] memPipe [RL];
    always @(posedge clk) begin
        memPipe[0] <= mem_en ? memWord(mem_addr) : {DW{1'b1}};
        for (int k = 1; k < RL; k++) memPipe[k] <= memPipe[k-1];
    end
    assign mem_rdata = memPipe[RL-1];

    int nCmp = 0, nBad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: per-PE bookkeeping plus a queue of reads due back at a given edge
    typedef struct {int due; int pe; logic [AW-1:0] a;} fl_t;
    fl_t           q[$];
    int            n, mMode, mWords, mRr;
    bit            mPend [NP];
    logic [AW-1:0] mAddr [NP];
    int            mIss [NP], mRcv [NP];
    logic [NP-1:0] mRdDone, eRspV;
    bit            mErr, eMemEn, eDone;
    logic [AW-1:0] eMemAddr;
    logic [DW-1:0] eRspD;
    int            enCnt, doneCnt, busyCnt;
    int            rspOrder[$];

    task automatic modelReset();
        mMode = M_IDLE; mWords = 0; mRr = 0; mErr = 0; q.delete();
        eMemEn = 0; eDone = 0; eRspV = '0; mRdDone = '0;
        for (int i = 0; i < NP; i++) begin
            mPend[i] = 0; mAddr[i] = '0; mIss[i] = 0; mRcv[i] = 0;
        end
    endtask

    task automatic modelEdge();
        bit allIss, errEv, drainDone;
        int g;
        logic [NP-1:0] acc;
        fl_t f;
        n++;
        allIss = 1;
        for (int i = 0; i < NP; i++) if (mIss[i] != mWords) allIss = 0;
        drainDone = (mMode == M_DRAIN) && q.size() == 0;
        eDone = drainDone;
        eRspV = '0;
        if (q.size() > 0 && q[0].due == n) begin
            f = q.pop_front();
            eRspV[f.pe] = 1'b1;
            eRspD = memWord(f.a);
            mRcv[f.pe]++;
            if (mRcv[f.pe] == mWords) mRdDone[f.pe] = 1'b1;
        end
        acc = '0;
        errEv = start && mMode != M_IDLE;
        for (int i = 0; i < NP; i++)
            if (req[i]) begin
                if (mMode == M_RUN && !mPend[i] && mIss[i] < mWords) acc[i] = 1'b1;
                else errEv = 1;
            end
        g = -1;
        for (int k = 0; k < NP; k++)
            if (g < 0 && mPend[(mRr + k) % NP]) g = (mRr + k) % NP;
        eMemEn = g >= 0;
        if (g >= 0) begin
            eMemAddr = mAddr[g];
            q.push_back('{n + RL + 1, g, mAddr[g]});
            mPend[g] = 0;
            mIss[g]++;
            mRr = (g + 1) % NP;
        end
        for (int i = 0; i < NP; i++)
            if (acc[i]) begin
                mPend[i] = 1;
                mAddr[i] = req_addr[i*AW +: AW];
            end
        if (start && mMode == M_IDLE) begin
            mWords = int'(cfg_words);
            for (int i = 0; i < NP; i++) begin mIss[i] = 0; mRcv[i] = 0; end
            mRdDone = (cfg_words == 0) ? '1 : '0;
            mErr = 0;
            mMode = M_RUN;
        end else begin
            mErr = mErr | errEv;
            if (mMode == M_RUN && allIss) mMode = M_DRAIN;
            else if (drainDone) mMode = M_IDLE;
        end
    endtask

    task automatic compare();
        check("mem_en", mem_en, eMemEn);
        if (eMemEn) check("mem_addr", mem_addr, eMemAddr);
        check("rsp_valid", rsp_valid, eRspV);
        if (eRspV != '0) check("rsp_data", rsp_data, eRspD);
        check("read_done", read_done, mRdDone);
        check("done", done, eDone);
        check("busy", busy, mMode != M_IDLE);
        check("err", err, mErr);
        enCnt += int'(mem_en);
        doneCnt += int'(done);
        busyCnt += int'(busy);
        for (int i = 0; i < NP; i++) if (rsp_valid[i]) rspOrder.push_back(i);
    endtask

    task automatic step(input logic s, input logic [CW-1:0] c, input logic [NP-1:0] r, input logic [NP*AW-1:0] a);
        start = s; cfg_words = c; req = r; req_addr = a;
        @(posedge clk);
        modelEdge();
        #1;
        compare();
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(1'b0, '0, '0, '0);
    endtask

    task automatic checkZero();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_read_done", read_done, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        start = 0; req = '0;
        #2 rst_n = 1'b0;
        #1 checkZero();
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NP-1:0]    r;
        logic [NP*AW-1:0] ra;
        int               sent [NP];
        int               cyc;
        n = 0; enCnt = 0; doneCnt = 0; busyCnt = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 checkZero();
        @(negedge clk) rst_n = 1'b1;

        // single PE, one word: PEs 0/2/3 never read so the run never completes
        step(1, 1, '0, '0);
        idle(1);
        ra = '0; ra[1*AW +: AW] = 10'h2A;
        doneCnt = 0;
        step(0, 0, 4'b0010, ra);
        idle(8);
        check("s1_read_done", read_done, 4'b0010);
        check("s1_no_done", doneCnt, 0);
        doReset();

        // two simultaneous rounds of all four PEs
        step(1, 2, '0, '0);
        for (int i = 0; i < NP; i++) ra[i*AW +: AW] = AW'(10'h100 + i);
        rspOrder.delete();
        step(0, 0, 4'hF, ra);
        idle(4);
        for (int i = 0; i < NP; i++) ra[i*AW +: AW] = AW'(10'h200 + i);
        step(0, 0, 4'hF, ra);
        idle(14);
        check("s2_rsp_count", rspOrder.size(), 8);
        for (int i = 0; i < rspOrder.size() && i < 8; i++) check("s2_order", rspOrder[i], i % NP);
        check("s2_idle", busy, 0);

        // three words per PE, each PE re-requesting on its readyToPick
        enCnt = 0; doneCnt = 0;
        for (int i = 0; i < NP; i++) sent[i] = 0;
        step(1, 3, '0, '0);
        r = '1; cyc = 0;
        while (mMode != M_IDLE && cyc < 100) begin
            ra = '0;
            for (int i = 0; i < NP; i++)
                if (r[i]) begin
                    ra[i*AW +: AW] = AW'(i * 16 + sent[i]);
                    sent[i]++;
                end
            step(0, 0, r, ra);
            r = '0;
            for (int i = 0; i < NP; i++) if (rsp_valid[i] && sent[i] < 3) r[i] = 1'b1;
            cyc++;
        end
        check("s3_mem_en_total", enCnt, 12);
        check("s3_done_once", doneCnt, 1);
        check("s3_read_done", read_done, 4'hF);
        check("s3_busy_end", busy, 0);

        // protocol errors: duplicate while pending, and a read beyond cfg_words
        enCnt = 0;
        step(1, 1, '0, '0);
        ra = '0; ra[0 +: AW] = 10'h005;
        step(0, 0, 4'b0001, ra);
        step(0, 0, 4'b0001, ra);
        idle(3);
        step(0, 0, 4'b0001, ra);
        for (int i = 0; i < NP; i++) ra[i*AW +: AW] = AW'(10'h300 + i);
        step(0, 0, 4'b1110, ra);
        idle(12);
        check("s4_err_sticky", err, 1);
        check("s4_mem_en_total", enCnt, 4);

        // zero-word run clears err and completes without reads
        enCnt = 0; doneCnt = 0; busyCnt = 0;
        step(1, 0, '0, '0);
        check("z_read_done", read_done, 4'hF);
        check("z_err_clear", err, 0);
        idle(4);
        check("z_busy_cycles", busyCnt, 2);
        check("z_done_once", doneCnt, 1);
        check("z_no_mem_en", enCnt, 0);

        // reset with two reads in flight
        step(1, 2, '0, '0);
        ra = '0; ra[0 +: AW] = 10'h011; ra[AW +: AW] = 10'h022;
        step(0, 0, 4'b0011, ra);
        idle(2);
        doReset();
        rspOrder.delete();
        idle(8);
        check("s5_no_rsp", rspOrder.size(), 0);

        // randomized runs
        for (int run = 0; run < 25; run++) begin
            bit aborted;
            aborted = 0; cyc = 0;
            step(1, CW'($urandom_range(0, 4)), '0, '0);
            while (mMode != M_IDLE && cyc < 300 && !aborted) begin
                r = '0; ra = '0;
                if (mMode == M_RUN)
                    for (int i = 0; i < NP; i++)
                        if ($urandom_range(0, 2) == 0 &&
                            ((!mPend[i] && mIss[i] < mWords) || $urandom_range(0, 15) == 0)) begin
                            r[i] = 1'b1;
                            ra[i*AW +: AW] = AW'($urandom_range(0, 1023));
                        end
                step($urandom_range(0, 40) == 0, CW'($urandom_range(0, 4)), r, ra);
                cyc++;
                if ($urandom_range(0, 299) == 0) begin
                    doReset();
                    aborted = 1;
                end
            end
            if (!aborted) check("run_end_busy", busy, 0);
            if (cyc >= 300) doReset();
            idle($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/pe_rdport_arbiter.md
Name: pe_rdport_arbiter

Overview:
- Shares one synchronous weight/activation memory read port among NUM_PE PE controllers.
- Each PE controller raises a one-cycle read request (its isRead strobe) with an address. The arbiter latches the request, grants the port round-robin, and returns the data to that PE with a one-hot valid. The valid drives that PE's readyToPick.
- Per-PE read-word counters produce each PE's readDone. A small run FSM reports when the whole batch has drained.

Parameters:
- NUM_PE, 4, number of requesting PE controllers (2..16)
- ADDR_W, 10, memory address width
- DATA_W, 64, memory data width
- RD_LAT, 2, memory read latency in cycles from mem_en to mem_rdata valid (1..4)
- CNT_W, 8, width of the per-PE word count

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: load cfg_words, clear counters, enter RUN
- cfg_words  in  CNT_W  reads each PE must complete this run (0 allowed)
- req  in  NUM_PE  per-PE one-cycle read request strobe
- req_addr  in  NUM_PE*ADDR_W  per-PE address; PE i uses bits [i*ADDR_W +: ADDR_W]; sampled with req[i]
- mem_en  out  1  memory read enable
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en
- rsp_valid  out  NUM_PE  one-hot, one-cycle data return (readyToPick)
- rsp_data  out  DATA_W  returned data, broadcast to all PEs
- read_done  out  NUM_PE  level; bit i high once PE i has received cfg_words responses this run (readDone)
- done  out  1  one-cycle pulse when the run completes
- busy  out  1  high while in RUN or DRAIN
- err  out  1  sticky protocol-error flag; cleared by reset or start

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - pending, counters, round-robin pointer and latency pipe are cleared.
  - mem_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, read_done=0, done=0, busy=0, err=0.
  - Reset mid-run aborts the run; in-flight reads are discarded and produce no rsp_valid.
- FSM states and transitions:
  - IDLE: req is ignored. start -> RUN.
  - RUN: when every PE has issued cfg_words reads -> DRAIN.
  - DRAIN: when the latency pipe is empty -> IDLE, asserting done for one cycle on the transition edge.
  - start while busy is ignored and sets err.
  - start with cfg_words=0: RUN -> DRAIN -> IDLE with no reads. done is asserted 2 cycles after start. read_done = all ones from the cycle after start.
- Request capture (RUN only):
  - req[i] sets pending[i] and latches addr[i].
  - req[i] is ignored and sets err if any of these hold: pending[i] already set, including in the grant cycle of PE i; PE i has already issued cfg_words reads; state is not RUN.
- Arbitration:
  - At most one grant per cycle.
  - Candidates are the pending PEs, searched starting at rr_ptr and wrapping modulo NUM_PE; the first found wins.
  - On grant to PE g: registered mem_en=1 and mem_addr=addr[g] on the next edge; pending[g] clears; issued count[g] increments; rr_ptr becomes (g+1) mod NUM_PE.
  - No pending PE: mem_en=0 and rr_ptr holds.
  - A request captured at edge t is eligible at edge t+1. Minimum req-to-mem_en latency is therefore 2 cycles.
- Return path:
  - Tag pipe is a one-hot PE id, RD_LAT+1 stages deep, aligned with mem_en.
  - rsp_data is registered from mem_rdata. rsp_valid[g] fires exactly once, RD_LAT+1 cycles after mem_en for that grant.
  - Back-to-back grants return in issue order with one response per cycle.
- read_done[i]: set on the rsp_valid[i] cycle that brings PE i's received count to cfg_words. Held until the next start or reset.
- Widths: counters are CNT_W; the issue count saturates at cfg_words, and excess requests are handled by the err rule.

Test Plan:
- Single PE, NUM_PE=4, RD_LAT=2, cfg_words=1: start, then req[1] with addr 0x2A two cycles later.
  -> mem_en with mem_addr=0x2A 2 cycles after req.
  -> rsp_valid=4'b0010 3 cycles after that, rsp_data = memory[0x2A].
  -> read_done[1]=1 in the same cycle; done never, since PEs 0, 2 and 3 are still owed reads.
- All four PEs request in the same cycle:
  -> grants in order 0, 1, 2, 3 on consecutive cycles.
  -> the next simultaneous round starts from rr_ptr=0 again, because the pointer wrapped after PE 3.
  -> responses return 0, 1, 2, 3 with no gaps.
- cfg_words=3 with all PEs looping on readyToPick:
  -> 12 mem_en pulses in total.
  -> read_done=4'hF after the last response.
  -> done pulses exactly once, 1 cycle after the last rsp_valid; busy drops with it.
- Protocol errors: req[2] while pending[2]=1, and a 4th req with cfg_words=3.
  -> err=1 and stays set.
  -> no extra mem_en; err is cleared by the next start.
- Reset asserted with 2 reads in flight:
  -> all outputs 0 immediately; no rsp_valid after release.
  -> a new start runs cleanly.
- start with cfg_words=0:
  -> busy for 2 cycles, done pulse, read_done=4'hF, no mem_en.
